// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: condition codes,
// NZCV bit positions and the flag-write group mask helper.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Bits of NZCV owned by write group g when the flags are split into nbits groups.
  function automatic logic [3:0] flag_group_mask(int unsigned g, int unsigned nbits);
    logic [3:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (b / (4 / nbits) == g) m[b] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: Cond x NZCV -> pass. Code 1111 is
// "never"; with COND_TRAP_EN defined it is also reported as undefined.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex,
  output logic       undef
);

  logic n, z, c, v, ge;

  always_comb begin
    n  = flags[FLAG_N];
    z  = flags[FLAG_Z];
    c  = flags[FLAG_C];
    v  = flags[FLAG_V];
    ge = (n == v);
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~(c & ~z);
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = ~ge;
      COND_GT: cond_ex = ~z & ge;
      COND_LE: cond_ex = ~(~z & ge);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
`ifdef COND_TRAP_EN
    undef = (cond == COND_NV);
`else
    undef = 1'b0;
`endif
  end

endmodule

// File: rtl/cond_unit_pipe.sv
// Conditional-execution unit: NZCV register with grouped writes, gated write
// controls, M-stage pipeline registers and a flag snapshot stack. Optional
// undefined-condition trap is enabled by defining COND_TRAP_EN.
module cond_unit_pipe
  import cond_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned FLAGW_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic [3:0]            Cond,
  input  logic [3:0]            ALUFlags,
  input  logic [FLAGW_BITS-1:0] FlagW,
  input  logic                  PCS,
  input  logic                  RegW,
  input  logic                  MemW,
  input  logic                  save,
  input  logic                  restore,
  output logic                  CondEx,
  output logic                  PCSrc,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  PCSrcM,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [3:0]            Flags,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_err,
  output logic                  UndefTrap
`ifdef COND_TRAP_EN
  ,
  output logic                  UndefTrapM
`endif
);

  localparam int unsigned PW = $clog2(STACK_DEPTH + 1);

  logic [3:0]    flags_q, flags_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          err_q, err_d;
  logic [3:0]    stack_q [STACK_DEPTH];
  logic [3:0]    stack_d [STACK_DEPTH];
  logic [3:0]    stack_top;
  logic          pcsrc_m_q, pcsrc_m_d;
  logic          regwrite_m_q, regwrite_m_d;
  logic          memwrite_m_q, memwrite_m_d;
  logic          undef;
  logic          flag_wr;

  cond_eval u_cond_eval (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (CondEx),
    .undef   (undef)
  );

  always_comb begin
    PCSrc       = PCS  & CondEx & ~flush;
    RegWrite    = RegW & CondEx & ~flush;
    MemWrite    = MemW & CondEx & ~flush;
    UndefTrap   = undef & ~flush;
    Flags       = flags_q;
    stack_err   = err_q;
    stack_full  = (ptr_q == PW'(STACK_DEPTH));
    stack_empty = (ptr_q == '0);
    PCSrcM      = pcsrc_m_q;
    RegWriteM   = regwrite_m_q;
    MemWriteM   = memwrite_m_q;
  end

  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (ptr_q == PW'(i + 1)) stack_top = stack_q[i];
    end
  end

  // Restore takes priority over both the ALU write and a same-cycle save;
  // a save pushes the pre-write flags.
  always_comb begin
    flags_d = flags_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    stack_d = stack_q;
    flag_wr = en & ~flush & CondEx;
    if (restore) begin
      if (stack_empty) begin
        err_d = 1'b1;
      end else begin
        flags_d = stack_top;
        ptr_d   = ptr_q - 1'b1;
      end
    end else begin
      for (int unsigned g = 0; g < FLAGW_BITS; g++) begin
        if (flag_wr && FlagW[g]) begin
          flags_d = (flags_d & ~flag_group_mask(g, FLAGW_BITS))
                  | (ALUFlags & flag_group_mask(g, FLAGW_BITS));
        end
      end
      if (save) begin
        if (stack_full) begin
          err_d = 1'b1;
        end else begin
          for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (ptr_q == PW'(i)) stack_d[i] = flags_q;
          end
          ptr_d = ptr_q + 1'b1;
        end
      end
    end
    pcsrc_m_d    = en ? PCSrc    : pcsrc_m_q;
    regwrite_m_d = en ? RegWrite : regwrite_m_q;
    memwrite_m_d = en ? MemWrite : memwrite_m_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q      <= '0;
      ptr_q        <= '0;
      err_q        <= 1'b0;
      pcsrc_m_q    <= 1'b0;
      regwrite_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      ptr_q        <= ptr_d;
      err_q        <= err_d;
      pcsrc_m_q    <= pcsrc_m_d;
      regwrite_m_q <= regwrite_m_d;
      memwrite_m_q <= memwrite_m_d;
    end
  end

  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

`ifdef COND_TRAP_EN
  logic undef_m_q, undef_m_d;

  always_comb begin
    undef_m_d  = en ? UndefTrap : undef_m_q;
    UndefTrapM = undef_m_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) undef_m_q <= 1'b0;
    else        undef_m_q <= undef_m_d;
  end
`endif

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Self-checking bench for cond_unit_pipe: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_cond_unit_pipe;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FWB   = 2;

  logic clk = 1'b0;
  logic reset, en, flush, PCS, RegW, MemW, save, restore;
  logic [3:0] Cond, ALUFlags;
  logic [FWB-1:0] FlagW;
  logic CondEx, PCSrc, RegWrite, MemWrite, PCSrcM, RegWriteM, MemWriteM;
  logic [3:0] Flags;
  logic stack_full, stack_empty, stack_err, UndefTrap;
`ifdef COND_TRAP_EN
  logic UndefTrapM;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cond_unit_pipe #(.STACK_DEPTH(DEPTH), .FLAGW_BITS(FWB)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .save(save), .restore(restore), .CondEx(CondEx), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .PCSrcM(PCSrcM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .Flags(Flags),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err),
    .UndefTrap(UndefTrap)
`ifdef COND_TRAP_EN
    , .UndefTrapM(UndefTrapM)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [3:0] m_flags = '0;
  logic [3:0] m_stack[$];
  logic m_err = 1'b0, m_pc = 1'b0, m_rw = 1'b0, m_mw = 1'b0, m_ut = 1'b0;

  function automatic logic passes(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;            1: return !z;
      2: return cy;           3: return !cy;
      4: return n;            5: return !n;
      6: return v;            7: return !v;
      8: return cy && !z;     9: return !(cy && !z);
      10: return n == v;      11: return n != v;
      12: return !z && n == v; 13: return z || n != v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic trap_exp(logic [3:0] c, logic fl);
`ifdef COND_TRAP_EN
    return (c == 4'hF) && !fl;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    logic p;
    logic [3:0] nf;
    if (!reset) begin
      m_flags = '0; m_stack.delete(); m_err = 0;
      m_pc = 0; m_rw = 0; m_mw = 0; m_ut = 0;
    end else begin
      p = passes(Cond, m_flags);
      if (en) begin
        m_pc = PCS && p && !flush;
        m_rw = RegW && p && !flush;
        m_mw = MemW && p && !flush;
        m_ut = trap_exp(Cond, flush);
      end
      nf = m_flags;
      if (restore) begin
        if (m_stack.size() == 0) m_err = 1;
        else nf = m_stack.pop_back();
      end else begin
        for (int b = 0; b < 4; b++)
          if (en && !flush && p && FlagW[b / (4 / FWB)]) nf[b] = ALUFlags[b];
        if (save) begin
          if (m_stack.size() == DEPTH) m_err = 1;
          else m_stack.push_back(m_flags);
        end
      end
      m_flags = nf;
    end
  end

  always @(negedge clk) begin
    logic p;
    p = passes(Cond, m_flags);
    chk("CondEx",     CondEx,     p);
    chk("PCSrc",      PCSrc,      PCS && p && !flush);
    chk("RegWrite",   RegWrite,   RegW && p && !flush);
    chk("MemWrite",   MemWrite,   MemW && p && !flush);
    chk("UndefTrap",  UndefTrap,  trap_exp(Cond, flush));
    chk("Flags",      Flags,      m_flags);
    chk("PCSrcM",     PCSrcM,     m_pc);
    chk("RegWriteM",  RegWriteM,  m_rw);
    chk("MemWriteM",  MemWriteM,  m_mw);
    chk("stack_full", stack_full, m_stack.size() == DEPTH);
    chk("stack_empty", stack_empty, m_stack.size() == 0);
    chk("stack_err",  stack_err,  m_err);
`ifdef COND_TRAP_EN
    chk("UndefTrapM", UndefTrapM, m_ut);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] lifo [4];
    lifo[0] = 4'b0100; lifo[1] = 4'b0011; lifo[2] = 4'b0010; lifo[3] = 4'b0001;
    reset = 0; en = 1; flush = 0; Cond = 0; ALUFlags = 0; FlagW = 0;
    PCS = 0; RegW = 0; MemW = 0; save = 0; restore = 0;
    tick(); tick();
    chk("rst_flags", Flags, 0);
    chk("rst_empty", stack_empty, 1);
    chk("rst_full", stack_full, 0);
    chk("rst_err", stack_err, 0);
    chk("rst_regwm", RegWriteM, 0);

    reset = 1; Cond = 4'b0000; #1;
    chk("eq_zero_flags", CondEx, 0);
    Cond = 4'b1110; ALUFlags = 4'b0100; FlagW = 2'b11; tick();
    chk("flags_0100", Flags, 4'b0100);
    Cond = 4'b0000; FlagW = 0; #1;
    chk("eq_pass", CondEx, 1);

    Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b11; tick();
    ALUFlags = 4'b1111; FlagW = 2'b01; tick();
    chk("group_cv", Flags, 4'b0011);
    Cond = 4'b0000; FlagW = 2'b11; #1;
    chk("eq_fail", CondEx, 0);
    tick();
    chk("no_write_on_fail", Flags, 4'b0011);

    Cond = 4'b1110; ALUFlags = 4'b1001; FlagW = 2'b11; tick();
    FlagW = 0; Cond = 4'b1010; #1;
    chk("ge_pass", CondEx, 1);
    RegW = 1; MemW = 1; flush = 1; #1;
    chk("flush_regwrite", RegWrite, 0);
    tick();
    chk("flush_regwm", RegWriteM, 0);
    flush = 0; #1;
    chk("regwrite", RegWrite, 1);
    tick();
    chk("regwm", RegWriteM, 1);
    chk("memwm", MemWriteM, 1);
    en = 0; RegW = 0; MemW = 0; flush = 1; tick();
    chk("stall_hold", RegWriteM, 1);
    en = 1; flush = 0; tick();
    chk("regwm_clear", RegWriteM, 0);

    Cond = 4'b1110; ALUFlags = 4'b0001; FlagW = 2'b11; tick();
    save = 1;
    for (int k = 0; k < 5; k++) begin
      ALUFlags = 4'(k + 2);
      tick();
      if (k == 3) begin
        chk("full_after4", stack_full, 1);
        chk("no_err_after4", stack_err, 0);
      end
      if (k == 4) chk("err_after5", stack_err, 1);
    end
    chk("flags_after_saves", Flags, 4'b0110);
    save = 0; FlagW = 0; restore = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lifo_pop", Flags, lifo[k]);
    end
    tick();
    chk("underflow_flags", Flags, 4'b0001);
    chk("underflow_err", stack_err, 1);
    restore = 0;

    ALUFlags = 4'b1010; FlagW = 2'b11; tick();
    save = 1; ALUFlags = 4'b0101; tick();
    chk("save_with_write", Flags, 4'b0101);
    restore = 1; FlagW = 0; tick();
    chk("save_restore_flags", Flags, 4'b1010);
    chk("save_restore_empty", stack_empty, 1);
    save = 0; restore = 0;

    Cond = 4'b1111; RegW = 1; #1;
    chk("nv_condex", CondEx, 0);
    chk("nv_regwrite", RegWrite, 0);
`ifdef COND_TRAP_EN
    chk("nv_trap", UndefTrap, 1);
`else
    chk("nv_trap", UndefTrap, 0);
`endif
    tick();

    save = 1; en = 0; reset = 0; tick();
    chk("reset_wins_flags", Flags, 0);
    chk("reset_wins_err", stack_err, 0);
    chk("reset_wins_empty", stack_empty, 1);
    reset = 1; save = 0; en = 1;

    for (int i = 0; i < 300; i++) begin
      Cond     = 4'($urandom);
      ALUFlags = 4'($urandom);
      FlagW    = FWB'($urandom);
      PCS      = 1'($urandom);
      RegW     = 1'($urandom);
      MemW     = 1'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 4) == 0);
      save     = ($urandom_range(0, 3) == 0);
      restore  = ($urandom_range(0, 4) == 0);
      reset    = ($urandom_range(0, 59) != 0);
      tick();
    end
    reset = 1; save = 0; restore = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
